// File: rtl/bus_grant_arbiter.sv
// ----------------------------------------------------------------------------
// bus_grant_arbiter
//
// Purpose:
//   Produces the registered 5-bit one-hot select for the shared 16-bit
//   datapath bus multiplexer. Five requestors (0=PC, 1=MDR, 2=ALU, 3=MARMUX,
//   4=spare) raise level requests. Grants rotate round-robin. A grantee that
//   holds the bus while someone else waits is cut off after HOLD_MAX cycles.
//   An all-zero grant leaves the bus undriven, so it reads as zero.
//
// Parameters:
//   HOLD_MAX  maximum consecutive grant cycles while another requestor waits
//             (0 = unlimited, legal range 0..255)
//   CNT_W     hold counter width, 2**CNT_W must exceed HOLD_MAX
//
// Ports:
//   Clk          in   1  system clock, all state on the rising edge
//   Reset        in   1  asynchronous active-high reset
//   Req          in   5  level requests, bit i = requestor i
//   Grant        out  5  registered one-hot grant or 5'b00000 (mux Select)
//   GrantIdx     out  3  binary index of the grantee, 3'd7 when Grant == 0
//   Busy         out  1  high while Grant != 0
//   HoldExpired  out  1  one-cycle pulse after a grant is cut by the hold limit
//
// Build option:
//   BUS_ARB_TURNAROUND_EN  when defined, every owner change passes through
//                          a one-cycle GAP with Grant == 0 so that two bus
//                          drivers never overlap.
// ----------------------------------------------------------------------------
module bus_grant_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] Req,
  output logic [4:0] Grant,
  output logic [2:0] GrantIdx,
  output logic       Busy,
  output logic       HoldExpired
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
`ifdef BUS_ARB_TURNAROUND_EN
  localparam logic [1:0] ST_GAP   = 2'd2;
`endif

  localparam logic [2:0] IDX_NONE = 3'd7;
  localparam logic [2:0] IDX_LAST = 3'd4;

  // Counter value seen during the final permitted cycle of a contested grant.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
  localparam bit HOLD_EN = (HOLD_MAX != 0);

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // First requestor after 'last' in circular order 0..4; IDX_NONE if none.
  function automatic logic [2:0] rr_pick(input logic [4:0] req,
                                         input logic [2:0] last);
    logic [2:0] idx;
    logic       found;
    logic [2:0] j;
    idx   = IDX_NONE;
    found = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      j = 3'((int'(last) + k) % 5);
      if (!found && req[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [4:0] to_onehot(input logic [2:0] idx);
    return (idx <= IDX_LAST) ? (5'b00001 << idx) : 5'b00000;
  endfunction

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,   state_d;
  logic [4:0]       grant_q,   grant_d;
  logic [2:0]       last_q,    last_d;     // round-robin pointer / owner index
  logic [CNT_W-1:0] cnt_q,     cnt_d;      // cycles held minus one
  logic             hexp_q,    hexp_d;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [4:0] others;        // waiting requestors other than the grantee
  logic       owner_req;     // grantee still requesting
  logic       hold_hit;      // grantee has used its full contested window
  logic       cnt_sat;
  logic [2:0] pick_all;      // pick over every request

  assign others    = Req & ~grant_q;
  assign owner_req = |(Req & grant_q);
  assign cnt_sat   = &cnt_q;
  assign pick_all  = rr_pick(Req, last_q);

  // Greater-or-equal keeps the hold bounded even when a second requestor
  // shows up after the grantee already ran past the limit uncontested.
  assign hold_hit  = HOLD_EN && (cnt_q >= HOLD_LAST);

`ifndef BUS_ARB_TURNAROUND_EN
  // The grantee is masked out, so on a hold revoke the bus goes elsewhere
  // and the old grantee re-queues behind everyone in round-robin order.
  logic [2:0] pick_other;
  assign pick_other = rr_pick(others, last_q);
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    hexp_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|Req) begin
          state_d = ST_GRANT;
          grant_d = to_onehot(pick_all);
          last_d  = pick_all;
          cnt_d   = '0;
        end
      end

      ST_GRANT: begin
        if (!owner_req || (hold_hit && |others)) begin
          // A grantee that drops Req on its last window cycle is an ordinary
          // release, so the pulse needs the grantee still requesting.
          hexp_d = owner_req;
          cnt_d  = '0;
`ifdef BUS_ARB_TURNAROUND_EN
          state_d = ST_GAP;
          grant_d = 5'b00000;
`else
          if (|others) begin
            grant_d = to_onehot(pick_other);
            last_d  = pick_other;
          end else begin
            state_d = ST_IDLE;
            grant_d = 5'b00000;
          end
`endif
        end else if (!cnt_sat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef BUS_ARB_TURNAROUND_EN
      ST_GAP: begin
        // The next owner is chosen from Req at GAP exit, not at revoke time;
        // last_q still holds the previous owner, which therefore ranks last.
        if (|Req) begin
          state_d = ST_GRANT;
          grant_d = to_onehot(pick_all);
          last_d  = pick_all;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        grant_d = 5'b00000;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (Reset) begin
      state_q <= ST_IDLE;
      grant_q <= 5'b00000;
      last_q  <= IDX_LAST;    // requestor 0 is first in line after reset
      cnt_q   <= '0;
      hexp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      hexp_q  <= hexp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, all decoded from registered state
  // --------------------------------------------------------------------------
  always_comb begin
    unique case (grant_q)
      5'b00001: GrantIdx = 3'd0;
      5'b00010: GrantIdx = 3'd1;
      5'b00100: GrantIdx = 3'd2;
      5'b01000: GrantIdx = 3'd3;
      5'b10000: GrantIdx = 3'd4;
      default:  GrantIdx = IDX_NONE;
    endcase
  end

  assign Grant       = grant_q;
  assign Busy        = |grant_q;
  assign HoldExpired = hexp_q;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_grant_arbiter
//
// Two arbiters share clock and reset: u_dut (HOLD_MAX = 8) and u_dut0
// (HOLD_MAX = 0, unlimited hold). Each cycle both are compared against a
// reference model that tracks "who owns the bus, for how long, and who went
// last". Directed tables and sequences add fixed expected values on top.
// ----------------------------------------------------------------------------
module tb_bus_grant_arbiter;

  logic       Clk;
  logic       Reset;
  logic [4:0] req0, req1;
  logic [4:0] grant0, grant1;
  logic [2:0] idx0, idx1;
  logic       busy0, busy1;
  logic       hexp0, hexp1;

  int checks = 0;
  int errors = 0;

  bus_grant_arbiter #(.HOLD_MAX(8), .CNT_W(8)) u_dut (
    .Clk(Clk), .Reset(Reset), .Req(req0), .Grant(grant0),
    .GrantIdx(idx0), .Busy(busy0), .HoldExpired(hexp0)
  );

  bus_grant_arbiter #(.HOLD_MAX(0), .CNT_W(8)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .Req(req1), .Grant(grant1),
    .GrantIdx(idx1), .Busy(busy1), .HoldExpired(hexp1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // --------------------------------------------------------------------------
  // Reference model: owner index (-1 = nobody), cycles held, last owner.
  // --------------------------------------------------------------------------
  int m_owner [2];
  int m_held  [2];
  int m_last  [2];
  bit m_exp   [2];
  int m_hold  [2] = '{8, 0};

  function automatic int rr(input logic [4:0] r, input int last);
    for (int k = 1; k <= 5; k++) begin
      if (r[(last + k) % 5]) return (last + k) % 5;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u] = -1;
      m_held[u]  = 0;
      m_last[u]  = 4;
      m_exp[u]   = 1'b0;
    end
  endtask

  task automatic model_step(input int u, input logic [4:0] r);
    logic [4:0] others;
    bit         rel, cut;
    m_exp[u] = 1'b0;
    if (m_owner[u] < 0) begin
      // Idle, or the turnaround gap: both pick from the current requests.
      m_owner[u] = rr(r, m_last[u]);
      if (m_owner[u] >= 0) begin
        m_last[u] = m_owner[u];
        m_held[u] = 1;
      end
    end else begin
      others = r;
      others[m_owner[u]] = 1'b0;
      rel = !r[m_owner[u]];
      cut = !rel && (m_hold[u] > 0) && (m_held[u] >= m_hold[u]) && (others != 0);
      if (rel || cut) begin
        m_exp[u] = cut;
`ifdef BUS_ARB_TURNAROUND_EN
        m_owner[u] = -1;
`else
        m_owner[u] = rr(others, m_last[u]);
        if (m_owner[u] >= 0) begin
          m_last[u] = m_owner[u];
          m_held[u] = 1;
        end
`endif
      end else begin
        m_held[u]++;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_unit(input int u, input logic [4:0] g,
                              input logic [2:0] ix, input logic b,
                              input logic hx);
    int eg, ei;
    eg = (m_owner[u] < 0) ? 0 : (1 << m_owner[u]);
    ei = (m_owner[u] < 0) ? 7 : m_owner[u];
    check($sformatf("u%0d grant", u), int'(g), eg);
    check($sformatf("u%0d idx", u), int'(ix), ei);
    check($sformatf("u%0d busy", u), int'(b), int'(eg != 0));
    check($sformatf("u%0d hold_expired", u), int'(hx), int'(m_exp[u]));
    check($sformatf("u%0d onehot0", u), int'($onehot0(g)), 1);
  endtask

  // Drive requests, take one edge, advance the model, compare 1 ns later.
  task automatic cycle(input logic [4:0] r0, input logic [4:0] r1);
    req0 = r0;
    req1 = r1;
    @(posedge Clk);
    model_step(0, r0);
    model_step(1, r1);
    #1;
    compare_unit(0, grant0, idx0, busy0, hexp0);
    compare_unit(1, grant1, idx1, busy1, hexp1);
  endtask

  // Asserts reset between edges and checks that outputs clear at once.
  task automatic do_reset();
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    compare_unit(0, grant0, idx0, busy0, hexp0);
    compare_unit(1, grant1, idx1, busy1, hexp1);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table for u_dut, starting right after reset
  // --------------------------------------------------------------------------
  typedef struct {
    logic [4:0] req;
    logic [4:0] grant;
    logic [2:0] idx;
    logic       hexp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [4:0] r0, r1;
    int         p, pos, eidx, eg, ehx;

    vecs[0] = '{5'b10001, 5'b00001, 3'd0, 1'b0};   // 1-cycle latency, 0 first
`ifdef BUS_ARB_TURNAROUND_EN
    vecs[1] = '{5'b10000, 5'b00000, 3'd7, 1'b0};   // gap between owners
`else
    vecs[1] = '{5'b10000, 5'b10000, 3'd4, 1'b0};   // direct handover
`endif
    vecs[2] = '{5'b10000, 5'b10000, 3'd4, 1'b0};
    vecs[3] = '{5'b00000, 5'b00000, 3'd7, 1'b0};
    vecs[4] = '{5'b00100, 5'b00100, 3'd2, 1'b0};

    Reset = 1'b1;
    req0  = '0;
    req1  = '0;
    model_reset();
    #1;
    check("reset grant", int'(grant0), 0);
    check("reset idx", int'(idx0), 7);
    check("reset busy", int'(busy0), 0);
    check("reset hold_expired", int'(hexp0), 0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      cycle(vecs[i].req, 5'b00000);
      check($sformatf("vec%0d grant", i), int'(grant0), int'(vecs[i].grant));
      check($sformatf("vec%0d idx", i), int'(idx0), int'(vecs[i].idx));
      check($sformatf("vec%0d hold_expired", i), int'(hexp0), int'(vecs[i].hexp));
    end

    // Lone requestor 2 keeps the bus for 20 more cycles with no pulse.
    for (int i = 0; i < 20; i++) begin
      cycle(5'b00100, 5'b00000);
      check("lone grant", int'(grant0), 5'b00100);
      check("lone hold_expired", int'(hexp0), 0);
    end

    // Go idle (pointer stays at 2), then everybody requests.
    cycle(5'b00000, 5'b00000);
    cycle(5'b00000, 5'b00000);
`ifdef BUS_ARB_TURNAROUND_EN
    p = 9;
`else
    p = 8;
`endif
    for (int i = 0; i < 45; i++) begin
      cycle(5'b11111, 5'b00000);
      pos  = i % p;
      eidx = (3 + i / p) % 5;
      eg   = (pos < 8) ? (1 << eidx) : 0;
`ifdef BUS_ARB_TURNAROUND_EN
      ehx  = int'(pos == 8);
`else
      ehx  = int'(i > 0 && pos == 0);
`endif
      check("rotate grant", int'(grant0), eg);
      check("rotate hold_expired", int'(hexp0), ehx);
    end

    // Grantee 2 drops Req on its last window cycle while 3 waits.
    do_reset();
    cycle(5'b00100, 5'b00000);
    for (int i = 0; i < 7; i++) cycle(5'b01100, 5'b00000);
    cycle(5'b01000, 5'b00000);
    check("drop-at-limit hold_expired", int'(hexp0), 0);
`ifdef BUS_ARB_TURNAROUND_EN
    check("drop-at-limit gap", int'(grant0), 0);
    cycle(5'b01000, 5'b00000);
`endif
    check("drop-at-limit grant", int'(grant0), 5'b01000);

    // Reset in the middle of that grant clears outputs immediately.
    do_reset();
    check("mid reset grant", int'(grant0), 0);
    check("mid reset busy", int'(busy0), 0);
    check("mid reset idx", int'(idx0), 7);
    cycle(5'b11111, 5'b00000);
    check("post reset grant", int'(grant0), 5'b00001);

    // Unlimited hold: requestor 0 keeps the bus until it lets go.
    for (int i = 0; i < 30; i++) begin
      cycle(5'b00000, 5'b00011);
      check("unlimited grant", int'(grant1), 5'b00001);
      check("unlimited hold_expired", int'(hexp1), 0);
    end
    cycle(5'b00000, 5'b00010);
`ifdef BUS_ARB_TURNAROUND_EN
    check("unlimited gap", int'(grant1), 0);
    cycle(5'b00000, 5'b00010);
`endif
    check("unlimited handover", int'(grant1), 5'b00010);

    // Randomized traffic: requests change on roughly one cycle in six so
    // holds long enough to reach the limit occur regularly.
    r0 = 5'($urandom);
    r1 = 5'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) r0 = 5'($urandom);
      if ($urandom_range(0, 5) == 0) r1 = 5'($urandom);
      cycle(r0, r1);
      if (i == 1500) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
